// File: rtl/seq_frame_sink.sv
// seq_frame_sink: consumer end of the sample sequence stream.
// Accepts one frame of FRAME_LEN samples over valid/ready and reduces it to
// max, min, sum and count, announced by a one-cycle done pulse.
// Optional feature macro: SEQ_SINK_MONO_EN -- when defined, err flags any
// sample smaller than its predecessor within a frame (sticky until next start).
module seq_frame_sink #(
  parameter int W         = 32,
  parameter int FRAME_LEN = 100,
  parameter int CNT_W     = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [W-1:0]         in_data,
  output logic                 in_ready,
  output logic                 busy,
  output logic                 done,
  output logic [W-1:0]         max,
  output logic [W-1:0]         min,
  output logic [W+CNT_W-1:0]   sum,
  output logic [CNT_W-1:0]     count,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [W-1:0]       max_reg, min_reg;
  logic [W+CNT_W-1:0] sum_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               xfer;
  logic               last_sample;
  logic               start;

  assign xfer        = in_valid & in_ready;
  // The transfer that brings the count to FRAME_LEN closes the frame.
  assign last_sample = (count_reg == CNT_W'(FRAME_LEN - 1));
  assign start       = (state_reg == IDLE) & en;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic and state-decoded handshake/status outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en) state_next = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && last_sample) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame reduction: cleared on start, updated only on accepted samples,
  // otherwise held so the last frame's results stay visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_reg   <= '0;
      min_reg   <= '1;
      sum_reg   <= '0;
      count_reg <= '0;
    end else if (start) begin
      max_reg   <= '0;
      min_reg   <= '1;
      sum_reg   <= '0;
      count_reg <= '0;
    end else if (xfer) begin
      count_reg <= count_reg + 1'b1;
      sum_reg   <= sum_reg + {{CNT_W{1'b0}}, in_data};
      if (in_data > max_reg) max_reg <= in_data;
      if (in_data < min_reg) min_reg <= in_data;
    end
  end

`ifdef SEQ_SINK_MONO_EN
  logic [W-1:0] prev_reg;
  logic         err_reg;

  // Monotonic check: compare each sample against the previous one accepted in
  // this frame; the first sample (count 0) has no predecessor and is exempt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_reg <= '0;
      err_reg  <= 1'b0;
    end else if (start) begin
      err_reg  <= 1'b0;
    end else if (xfer) begin
      prev_reg <= in_data;
      if ((count_reg != '0) && (in_data < prev_reg)) err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign max   = max_reg;
  assign min   = min_reg;
  assign sum   = sum_reg;
  assign count = count_reg;

endmodule

// File: tb/tb_seq_frame_sink.sv
// Testbench for seq_frame_sink: three instances (FRAME_LEN 100, 4 and 1).
// Stimulus pushes expected frame summaries into per-instance queues; a
// monitor pops and compares whenever an instance raises done.
module tb_seq_frame_sink;

`ifdef SEQ_SINK_MONO_EN
  localparam logic MONO = 1'b1;
`else
  localparam logic MONO = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] mx;
    logic [31:0] mn;
    logic [38:0] sm;
    logic [6:0]  ct;
    logic        er;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        rstn, en, vld;
  logic [2:0][31:0]  din;
  logic [2:0]        rdy, bsy, dn, er;
  logic [2:0][31:0]  mx, mn;
  logic [2:0][38:0]  sm;
  logic [2:0][6:0]   ct;

  seq_frame_sink #(.W(32), .FRAME_LEN(100), .CNT_W(7)) dut0 (
    .clk(clk), .rst(rstn[0]), .en(en[0]), .in_valid(vld[0]), .in_data(din[0]),
    .in_ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .max(mx[0]), .min(mn[0]),
    .sum(sm[0]), .count(ct[0]), .err(er[0]));

  seq_frame_sink #(.W(32), .FRAME_LEN(4), .CNT_W(7)) dut1 (
    .clk(clk), .rst(rstn[1]), .en(en[1]), .in_valid(vld[1]), .in_data(din[1]),
    .in_ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .max(mx[1]), .min(mn[1]),
    .sum(sm[1]), .count(ct[1]), .err(er[1]));

  seq_frame_sink #(.W(32), .FRAME_LEN(1), .CNT_W(7)) dut2 (
    .clk(clk), .rst(rstn[2]), .en(en[2]), .in_valid(vld[2]), .in_data(din[2]),
    .in_ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .max(mx[2]), .min(mn[2]),
    .sum(sm[2]), .count(ct[2]), .err(er[2]));

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   n_xfer [3];
  int   prev_done0 = 0, last_done0 = 0;
  exp_t q0[$], q1[$], q2[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else
      $display("ok   %s = %0h", name, act);
  endtask

  // Monitor-side comparison of one done pulse against the queued expectation.
  task automatic mon_check(input int i);
    exp_t e;
    bit   got;
    got = 1'b0;
    e   = '0;
    case (i)
      0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
    endcase
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_done: dut%0d raised done with nothing expected (cycle %0d)", i, cyc);
    end else begin
      $display("done dut%0d cycle %0d", i, cyc);
      chk("done_max",   64'(mx[i]),  64'(e.mx));
      chk("done_min",   64'(mn[i]),  64'(e.mn));
      chk("done_sum",   64'(sm[i]),  64'(e.sm));
      chk("done_count", 64'(ct[i]),  64'(e.ct));
      chk("done_err",   64'(er[i]),  64'(e.er));
      chk("done_ready_low", 64'(rdy[i]), 64'd0);
      chk("done_busy_low",  64'(bsy[i]), 64'd0);
    end
    if (i == 0) begin
      prev_done0 = last_done0;
      last_done0 = cyc;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (dn[i] === 1'b1) mon_check(i);
    end
  end

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic expect_frame(input int i, input exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Pulse en for one IDLE cycle; at the following negedge the DUT is in RUN
  // with cleared results.
  task automatic start(input int i);
    @(negedge clk); en[i] = 1'b1;
    @(negedge clk); en[i] = 1'b0;
    n_xfer[i] = 0;
    chk("start_busy",       64'(bsy[i]), 64'd1);
    chk("start_clr_count",  64'(ct[i]),  64'd0);
    chk("start_clr_err",    64'(er[i]),  64'd0);
  endtask

  // Offer one sample after 'gap' idle cycles; during the gap the count must
  // not move.
  task automatic push(input int i, input logic [31:0] d, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk); vld[i] = 1'b0; din[i] = 32'hA5A5A5A5;
      chk("stall_count", 64'(ct[i]), 64'(n_xfer[i]));
    end
    @(negedge clk); vld[i] = 1'b1; din[i] = d;
    t = 0;
    while (rdy[i] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (rdy[i] !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: dut%0d in_ready=%b required 1", i, rdy[i]);
    end else
      n_xfer[i]++;
  endtask

  task automatic idle_inputs(input int i);
    @(negedge clk); vld[i] = 1'b0; din[i] = '0;
  endtask

  task automatic wait_done(input int i);
    int t;
    t = 0;
    while (qsize(i) != 0 && t < 500) begin @(negedge clk); t++; end
    chk("done_seen", 64'(qsize(i)), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = '0; en = '0; vld = '0; din = '0;
    repeat (3) @(negedge clk);
    // Reset values.
    chk("rst_count", 64'(ct[0]),  64'd0);
    chk("rst_max",   64'(mx[0]),  64'd0);
    chk("rst_min",   64'(mn[0]),  64'hFFFFFFFF);
    chk("rst_sum",   64'(sm[0]),  64'd0);
    chk("rst_ready", 64'(rdy[0]), 64'd0);
    chk("rst_busy",  64'(bsy[0]), 64'd0);
    chk("rst_err",   64'(er[0]),  64'd0);
    rstn = '1;
    @(negedge clk);
    chk("idle_ready_low", 64'(rdy[0]), 64'd0);

    // Reset in the middle of a frame: partial frame discarded, no done.
    start(0);
    for (int k = 0; k < 5; k++) push(0, 32'(10 + k), 0);
    idle_inputs(0);
    chk("partial_count", 64'(ct[0]), 64'd5);
    rstn[0] = 1'b0;
    #1;
    chk("midrst_count", 64'(ct[0]),  64'd0);
    chk("midrst_max",   64'(mx[0]),  64'd0);
    chk("midrst_min",   64'(mn[0]),  64'hFFFFFFFF);
    chk("midrst_sum",   64'(sm[0]),  64'd0);
    chk("midrst_busy",  64'(bsy[0]), 64'd0);
    chk("midrst_ready", 64'(rdy[0]), 64'd0);
    chk("midrst_err",   64'(er[0]),  64'd0);
    repeat (3) @(negedge clk);
    rstn[0] = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 1..100 with valid every cycle.
    expect_frame(0, '{mx: 32'd100, mn: 32'd1, sm: 39'd5050, ct: 7'd100, er: 1'b0});
    start(0);
    for (int k = 1; k <= 100; k++) push(0, 32'(k), 0);
    idle_inputs(0);
    wait_done(0);
    @(negedge clk);
    chk("post_idle_ready", 64'(rdy[0]), 64'd0);
    // Samples offered while not ready are ignored; results held.
    vld[0] = 1'b1; din[0] = 32'd999;
    repeat (3) @(negedge clk);
    chk("held_count", 64'(ct[0]), 64'd100);
    chk("held_max",   64'(mx[0]), 64'd100);
    chk("held_sum",   64'(sm[0]), 64'd5050);
    vld[0] = 1'b0;

    // FRAME_LEN=4 with gaps, including an all-ones sample.
    expect_frame(1, '{mx: 32'hFFFFFFFF, mn: 32'd3, sm: 39'h10000000C, ct: 7'd4, er: MONO});
    start(1);
    push(1, 32'd7, 2);
    push(1, 32'd3, 1);
    push(1, 32'hFFFFFFFF, 3);
    push(1, 32'd3, 0);
    idle_inputs(1);
    wait_done(1);

    // Non-monotonic frame 1,2,2,1 then an ascending frame.
    expect_frame(1, '{mx: 32'd2, mn: 32'd1, sm: 39'd6, ct: 7'd4, er: MONO});
    start(1);
    push(1, 32'd1, 0);
    push(1, 32'd2, 1);
    push(1, 32'd2, 0);
    push(1, 32'd1, 0);
    idle_inputs(1);
    wait_done(1);
    expect_frame(1, '{mx: 32'd4, mn: 32'd1, sm: 39'd10, ct: 7'd4, er: 1'b0});
    start(1);
    for (int k = 1; k <= 4; k++) push(1, 32'(k), 0);
    idle_inputs(1);
    wait_done(1);

    // FRAME_LEN=1: the first transfer completes the frame.
    expect_frame(2, '{mx: 32'hDEADBEEF, mn: 32'hDEADBEEF, sm: 39'hDEADBEEF, ct: 7'd1, er: 1'b0});
    start(2);
    push(2, 32'hDEADBEEF, 1);
    idle_inputs(2);
    wait_done(2);

    // en held high: two back-to-back frames of constant 5.
    expect_frame(0, '{mx: 32'd5, mn: 32'd5, sm: 39'd500, ct: 7'd100, er: 1'b0});
    expect_frame(0, '{mx: 32'd5, mn: 32'd5, sm: 39'd500, ct: 7'd100, er: 1'b0});
    @(negedge clk); en[0] = 1'b1;
    for (int k = 0; k < 200; k++) push(0, 32'd5, 0);
    @(negedge clk); vld[0] = 1'b0; en[0] = 1'b0;
    wait_done(0);
    chk("b2b_done_spacing", 64'(last_done0 - prev_done0), 64'd102);
    repeat (3) @(negedge clk);
    chk("no_third_frame_busy", 64'(bsy[0]), 64'd0);

    repeat (5) @(negedge clk);
    chk("pending_expectations", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
